bbox_extractor: RTL
===================

# bbox_extractor

Per-frame bounding-box extractor for the VGA pixel pipeline, and the inverse of the per-pixel box membership test. Pixels arrive as a scanned stream of DrawX/DrawY coordinates with a hit flag. The block tracks the min/max X and Y of all hit pixels in the frame. At frame end it publishes the box in center/half-extent form (CX, CY, X_width, Y_height), which feeds straight back into the box membership checker for overlays, collision and tracking logic.

## Interface
Parameters:
- COORD_W, 10, coordinate width (DrawX/DrawY range 0..1023).
- MIN_COUNT, 1, minimum hit-pixel count for a box to be reported valid (1..65535).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DrawX  input  COORD_W  current pixel X.
- DrawY  input  COORD_W  current pixel Y.
- pixel_valid  input  1  DrawX/DrawY/pixel_hit are meaningful this cycle.
- pixel_hit  input  1  pixel belongs to the object; sampled only when pixel_valid=1.
- frame_end  input  1  single-cycle pulse after (or with) the last pixel of a frame.
- CX  output  COORD_W  published box center X.
- CY  output  COORD_W  published box center Y.
- X_width  output  COORD_W  published half-width.
- Y_height  output  COORD_W  published half-height.
- box_valid  output  1  published box contains ≥ MIN_COUNT hit pixels.
- box_done  output  1  one-cycle pulse when CX..box_valid update.
- hit_count  output  16  hit-pixel count of the published frame, saturating at 65535.

## Operation
- State machine: ACCUM, CALC, PUBLISH. Reset enters ACCUM with the accumulators cleared.
- Accumulators: minX/minY reset to all-ones, maxX/maxY reset to 0, cnt reset to 0, any_hit reset to 0.
- ACCUM: on pixel_valid && pixel_hit:
  - minX = min(minX, DrawX), maxX = max(maxX, DrawX), same for Y.
  - cnt increments, saturating at 65535; any_hit is set.
- ACCUM, frame_end=1: go to CALC.
  - If pixel_valid && pixel_hit in the same cycle, that pixel is included before the frame closes.
- CALC: register the extents.
  - sumX = minX + maxX, COORD_W+1 bits; diffX = maxX − minX; same for Y.
  - Latch cnt and any_hit into the snapshot.
  - Clear the accumulators to their reset values. Go to PUBLISH.
- PUBLISH: drive the outputs and return to ACCUM.
  - CX = sumX >> 1 (floor); X_width = (diffX + 1) >> 1 (ceil of diffX/2); same for Y.
  - This guarantees CX − X_width ≤ minX and maxX ≤ CX + X_width, so every hit pixel passes the inclusive membership test. The box may be one pixel larger on the low side when the extent is even-width.
  - box_valid = any_hit && (cnt ≥ MIN_COUNT); hit_count = cnt.
  - box_done = 1 for this cycle.
- No hits in the frame: CX = CY = X_width = Y_height = 0, box_valid = 0, hit_count = 0.
- Pixels and frame_end presented during CALC or PUBLISH are dropped. Upstream guarantees at least two idle cycles after frame_end (horizontal/vertical blanking).
- Outputs hold their last published values between box_done pulses.

## Timing
- Reset values: CX, CY, X_width, Y_height, hit_count = 0; box_valid = 0; box_done = 0; state = ACCUM.
- Reset is asynchronous. Asserting it mid-frame or in CALC/PUBLISH immediately clears all outputs and accumulators. No box_done is issued for the interrupted frame.
- Latency: frame_end sampled at edge t → CALC during cycle t+1 → outputs valid and box_done=1 after edge t+2. box_done is high for exactly one cycle.
- Throughput: one pixel per clock in ACCUM with no stalls. There is no backpressure.
- Back-to-back frames: the first pixel of the next frame is accepted on the cycle after PUBLISH.
- Width rules:
  - Sums use COORD_W+1 bits, so no overflow at 1023+1023.
  - diffX + 1 uses COORD_W+1 bits, so 1023−0+1 = 1024 → X_width = 512 fits.
  - The cnt comparator is 16-bit unsigned.

## Test plan
- Single hit at (320,240), frame_end → box_done at t+2. Required response: CX=320, CY=240, X_width=0, Y_height=0, box_valid=1, hit_count=1.
- Hits at (2,10) and (5,13), frame_end → CX=3, X_width=2, CY=11, Y_height=2, hit_count=2. Feeding the published box to the membership checker must accept both points.
- Extremes (0,0) and (1023,1023) → CX=511, X_width=512, CY=511, Y_height=512, with no overflow.
- Frame with zero hits, pixel_valid toggling → all box outputs 0, box_valid=0, box_done still pulses once.
- Hit asserted together with frame_end at (100,50), after an earlier hit at (90,50) → minX=90 and maxX=100 are both included: CX=95, X_width=5. The next frame starts clean with no carry-over of extents.
- MIN_COUNT=4 with 3 hits → box_valid=0, hit_count=3. Reset asserted mid-frame after 2 hits → outputs 0 immediately. The following full frame reports only post-reset hits.

Source files
------------

// File: rtl/bbox_extractor_if.sv
// Pixel-stream and published-box bundle for bbox_extractor.
// Upstream drives pixels/frame_end, the extractor drives the published box.
interface bbox_extractor_if #(
    parameter int COORD_W = 10
);
    // Handshake: there is no ready. A pixel is consumed on any rising edge where
    // pixel_valid=1 while the extractor is in ACCUM; in CALC/PUBLISH it is dropped.
    // frame_end is a one-cycle pulse, and box_done is a one-cycle pulse that marks
    // the edge on which CX..hit_count took new values.
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               pixel_valid;
    logic               pixel_hit;
    logic               frame_end;
    logic [COORD_W-1:0] CX;
    logic [COORD_W-1:0] CY;
    logic [COORD_W-1:0] X_width;
    logic [COORD_W-1:0] Y_height;
    logic               box_valid;
    logic               box_done;
    logic [15:0]        hit_count;
    logic [1:0]         state;

    modport master (
        output DrawX, DrawY, pixel_valid, pixel_hit, frame_end,
        input  CX, CY, X_width, Y_height, box_valid, box_done, hit_count, state
    );

    modport slave (
        input  DrawX, DrawY, pixel_valid, pixel_hit, frame_end,
        output CX, CY, X_width, Y_height, box_valid, box_done, hit_count, state
    );
endinterface

// File: rtl/bbox_extractor.sv
// Per-frame bounding-box extractor: tracks min/max of hit pixels and publishes the
// box as center/half-extent so every hit pixel passes the inclusive membership test.
module bbox_extractor #(
    parameter int COORD_W   = 10,
    parameter int MIN_COUNT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    bbox_extractor_if.slave   bus
);
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        CALC    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] COORD_ONES = '1;
    localparam logic [COORD_W:0]   ONE_EXT    = (COORD_W+1)'(1);
    localparam logic [15:0]        MIN_CNT    = 16'(MIN_COUNT);
    localparam logic [15:0]        CNT_MAX    = 16'hFFFF;

    state_t             state;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [15:0]        cnt;
    logic               any_hit;

    logic [COORD_W:0]   sum_x, sum_y;
    logic [COORD_W-1:0] diff_x, diff_y;
    logic [15:0]        snap_cnt;
    logic               snap_any;

    logic [COORD_W-1:0] cx, cy, x_width, y_height;
    logic               box_valid, box_done;
    logic [15:0]        hit_count;

    logic               take;
    logic [COORD_W:0]   sum_x_next, sum_y_next;
    logic [COORD_W:0]   span_x, span_y;

    assign take = bus.pixel_valid && bus.pixel_hit;

    // diff+1 is carried at COORD_W+1 bits so a full-range extent rounds up to 2^(COORD_W-1).
    always_comb begin
        sum_x_next = {1'b0, min_x} + {1'b0, max_x};
        sum_y_next = {1'b0, min_y} + {1'b0, max_y};
        span_x     = {1'b0, diff_x} + ONE_EXT;
        span_y     = {1'b0, diff_y} + ONE_EXT;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ACCUM;
            min_x     <= COORD_ONES;
            min_y     <= COORD_ONES;
            max_x     <= '0;
            max_y     <= '0;
            cnt       <= '0;
            any_hit   <= 1'b0;
            sum_x     <= '0;
            sum_y     <= '0;
            diff_x    <= '0;
            diff_y    <= '0;
            snap_cnt  <= '0;
            snap_any  <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            x_width   <= '0;
            y_height  <= '0;
            box_valid <= 1'b0;
            box_done  <= 1'b0;
            hit_count <= '0;
        end else begin
            box_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (take) begin
                        if (bus.DrawX < min_x) min_x <= bus.DrawX;
                        if (bus.DrawX > max_x) max_x <= bus.DrawX;
                        if (bus.DrawY < min_y) min_y <= bus.DrawY;
                        if (bus.DrawY > max_y) max_y <= bus.DrawY;
                        if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
                        any_hit <= 1'b1;
                    end
                    if (bus.frame_end) state <= CALC;
                end
                CALC: begin
                    sum_x    <= sum_x_next;
                    sum_y    <= sum_y_next;
                    diff_x   <= max_x - min_x;
                    diff_y   <= max_y - min_y;
                    snap_cnt <= cnt;
                    snap_any <= any_hit;
                    min_x    <= COORD_ONES;
                    min_y    <= COORD_ONES;
                    max_x    <= '0;
                    max_y    <= '0;
                    cnt      <= '0;
                    any_hit  <= 1'b0;
                    state    <= PUBLISH;
                end
                PUBLISH: begin
                    // Empty frame: the extents hold the all-ones/zero seeds, so force zeros.
                    if (snap_any) begin
                        cx       <= COORD_W'(sum_x >> 1);
                        cy       <= COORD_W'(sum_y >> 1);
                        x_width  <= COORD_W'(span_x >> 1);
                        y_height <= COORD_W'(span_y >> 1);
                    end else begin
                        cx       <= '0;
                        cy       <= '0;
                        x_width  <= '0;
                        y_height <= '0;
                    end
                    box_valid <= snap_any && (snap_cnt >= MIN_CNT);
                    hit_count <= snap_any ? snap_cnt : 16'd0;
                    box_done  <= 1'b1;
                    state     <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.CX        = cx;
    assign bus.CY        = cy;
    assign bus.X_width   = x_width;
    assign bus.Y_height  = y_height;
    assign bus.box_valid = box_valid;
    assign bus.box_done  = box_done;
    assign bus.hit_count = hit_count;
    assign bus.state     = state;
endmodule
